// File: rtl/main_mem_burst.sv
// Byte-addressed, big-endian burst memory model with accept/busy/valid handshake and range/alignment errors.
// Define BURST_WRAP_EN for critical-word-first wrapping bursts; linear bursts otherwise.
module main_mem_burst #(
    parameter int                      ADDRESS_SIZE  = 32,
    parameter int                      DATA_SIZE     = 32,
    parameter int                      MEM_SIZE      = 1048576,
    parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    wren,
    input  logic [ADDRESS_SIZE-1:0] addr,
    input  logic [1:0]              acc_size,
    input  logic [DATA_SIZE-1:0]    d_in,
    output logic [DATA_SIZE-1:0]    d_out,
    output logic                    d_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int BYTES  = DATA_SIZE / 8;
    localparam int LOG_B  = $clog2(BYTES);
    localparam int AW1    = ADDRESS_SIZE + 1;
    localparam int MEM_AW = $clog2(MEM_SIZE);
    localparam logic [AW1-1:0]          START_W    = {1'b0, START_ADDRESS};
    localparam logic [AW1-1:0]          MEM_SIZE_W = AW1'(MEM_SIZE);
    localparam logic [AW1-1:0]          ONE_W      = AW1'(1'b1);
    localparam logic [MEM_AW-1:0]       BYTES_M    = MEM_AW'(BYTES);
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ADDRESS_SIZE'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    logic [7:0] mem [MEM_SIZE];

    state_t                state_r;
    logic                  busy_r;
    logic                  d_valid_r;
    logic                  err_r;
    logic [DATA_SIZE-1:0]  d_out_r;
    logic [4:0]            beat_r;
    logic [4:0]            last_r;
    logic [MEM_AW-1:0]     cur_idx_r;
`ifdef BURST_WRAP_EN
    logic [MEM_AW-1:0]     blk_idx_r;
    logic [MEM_AW-1:0]     wrap_mask_r;
`endif

    logic [4:0]            beats_s;
    logic [AW1-1:0]        span_s;
    logic [AW1-1:0]        addr_w_s;
    logic [AW1-1:0]        blk_s;
    logic                  req_ok_s;
    logic [MEM_AW-1:0]     next_idx_s;

    // Assemble one big-endian word starting at a storage index.
    function automatic logic [DATA_SIZE-1:0] read_word(input logic [MEM_AW-1:0] idx);
        logic [DATA_SIZE-1:0] w;
        w = {DATA_SIZE{1'b0}};
        for (int j = 0; j < BYTES; j++) begin
            w[DATA_SIZE-1-8*j -: 8] = mem[idx + MEM_AW'(j)];
        end
        return w;
    endfunction

    // Decode request length and decide whether the request fits in storage.
    always_comb begin
        beats_s = 5'd1;
        case (acc_size)
            2'b00:   beats_s = 5'd1;
            2'b01:   beats_s = 5'd4;
            2'b10:   beats_s = 5'd8;
            2'b11:   beats_s = 5'd16;
            default: beats_s = 5'd1;
        endcase
        span_s   = AW1'(beats_s) << LOG_B;
        addr_w_s = {1'b0, addr};
`ifdef BURST_WRAP_EN
        blk_s    = addr_w_s & ~(span_s - ONE_W);
`else
        blk_s    = addr_w_s;
`endif
        // One extra bit of headroom keeps the end-of-range sum from wrapping.
        req_ok_s = (blk_s >= START_W)
                && (((blk_s - START_W) + span_s) <= MEM_SIZE_W)
                && ((addr & ALIGN_MASK) == {ADDRESS_SIZE{1'b0}});
    end

    // Storage index of the beat after the current one.
    always_comb begin
`ifdef BURST_WRAP_EN
        next_idx_s = blk_idx_r + ((cur_idx_r - blk_idx_r + BYTES_M) & wrap_mask_r);
`else
        next_idx_s = cur_idx_r + BYTES_M;
`endif
    end

    // Burst sequencer: accept/reject, beat counting and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            d_valid_r <= 1'b0;
            err_r     <= 1'b0;
            d_out_r   <= {DATA_SIZE{1'b0}};
            beat_r    <= 5'd0;
        end else begin
            err_r     <= 1'b0;
            d_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        if (req_ok_s) begin
                            state_r   <= wren ? ST_WR : ST_RD;
                            busy_r    <= 1'b1;
                            beat_r    <= 5'd0;
                            last_r    <= beats_s - 5'd1;
                            cur_idx_r <= MEM_AW'(addr_w_s - START_W);
`ifdef BURST_WRAP_EN
                            blk_idx_r   <= MEM_AW'(blk_s - START_W);
                            wrap_mask_r <= MEM_AW'(span_s - ONE_W);
`endif
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_RD, ST_WR: begin
                    if (state_r == ST_RD) begin
                        d_out_r   <= read_word(cur_idx_r);
                        d_valid_r <= 1'b1;
                    end
                    cur_idx_r <= next_idx_s;
                    beat_r    <= beat_r + 5'd1;
                    if (beat_r == last_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Commit one write beat per cycle; reset drops any beats not yet written.
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == ST_WR)) begin
            for (int j = 0; j < BYTES; j++) begin
                mem[cur_idx_r + MEM_AW'(j)] <= d_in[DATA_SIZE-1-8*j -: 8];
            end
        end
    end

    assign d_out   = d_out_r;
    assign d_valid = d_valid_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule
